// File: rtl/fir_out_fmt_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_fmt_if
// Description : FP29i result input handshake and FP16 output bus of the
//               FIR output formatting stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_out_fmt_if;
    logic        in_valid;
    logic        in_s;
    logic [5:0]  in_e;
    logic [21:0] in_m;
    logic        in_ready;
    logic [15:0] dout;
    logic        valid;

    // Producer side: the FIR ALU drives the result, the slow domain samples dout.
    modport master (
        output in_valid, in_s, in_e, in_m,
        input  in_ready, dout, valid
    );

    modport slave (
        input  in_valid, in_s, in_e, in_m,
        output in_ready, dout, valid
    );
endinterface
`default_nettype wire

// File: rtl/fir_out_fmt.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_fmt
// Description : Normalizes one FP29i FIR result, rounds it to IEEE FP16 and
//               holds valid long enough for the slow clock domain to sample.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_out_fmt #(
    parameter int EXP_BIAS29  = 31,
    parameter int HOLD_CYCLES = 4
) (
    input  wire logic    clk_fast,
    input  wire logic    rst_n,
    fir_out_fmt_if.slave bus,
    input  wire logic    clr_flags,
    output logic         ovf,
    output logic         unf,
    output logic         overrun
);

    localparam logic signed [7:0] c_EXP_OFS   = 8'(EXP_BIAS29 - 15);
    localparam logic        [3:0] c_HOLD_LAST = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_RND  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_in_ready;
    logic               w_accept;

    logic               r_s;
    logic [5:0]         r_e;
    logic [21:0]        r_m;
    logic [20:0]        r_shift;
    logic signed [7:0]  r_exp;
    logic [15:0]        r_dout;
    logic               r_valid;
    logic [3:0]         r_hold_cnt;
    logic               r_ovf;
    logic               r_unf;
    logic               r_overrun;

    logic [4:0]         w_lead;
    logic [4:0]         w_lz;
    logic [20:0]        w_shifted;
    logic signed [7:0]  w_exp_norm;

    logic [9:0]         w_frac;
    logic               w_guard;
    logic               w_sticky;
    logic               w_rnd_up;
    logic [10:0]        w_frac_sum;
    logic signed [7:0]  w_exp_rnd;
    logic [15:0]        w_result;
    logic               w_set_ovf;
    logic               w_set_unf;
    logic               w_overrun_evt;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_NORM;
                end
            end
            S_NORM:  w_state_nxt = S_RND;
            S_RND:   w_state_nxt = S_OUT;
            S_OUT: begin
                if (r_hold_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Normalize: leading one to bit 21, exponent rebased to FP16 bias
    // ------------------------------------------------------------------
    always_comb begin
        w_lead = 5'd0;
        for (int i = 0; i < 22; i++) begin
            if (r_m[i]) begin
                w_lead = 5'(i);
            end
        end
    end

    // The explicit leading one (bit 21) is dropped; only the fraction bits travel on.
    assign w_lz       = 5'd21 - w_lead;
    assign w_shifted  = 21'(r_m << w_lz);
    assign w_exp_norm = $signed({2'b00, r_e}) - c_EXP_OFS - $signed({3'b000, w_lz});

    // ------------------------------------------------------------------
    // Round to nearest even and classify
    // ------------------------------------------------------------------
    assign w_frac     = r_shift[20:11];
    assign w_guard    = r_shift[10];
    assign w_sticky   = |r_shift[9:0];
    assign w_rnd_up   = w_guard & (w_sticky | w_frac[0]);
    assign w_frac_sum = {1'b0, w_frac} + {10'd0, w_rnd_up};
    // On carry the low ten sum bits are already zero, so only the exponent moves.
    assign w_exp_rnd  = r_exp + $signed({7'd0, w_frac_sum[10]});

    always_comb begin
        w_result  = {r_s, 15'h0000};
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (r_m == 22'd0) begin
            w_result = {r_s, 15'h0000};
        end else if (w_exp_rnd >= 8'sd31) begin
            w_result  = {r_s, 5'h1F, 10'h000};
            w_set_ovf = 1'b1;
        end else if (w_exp_rnd <= 8'sd0) begin
            w_result  = {r_s, 15'h0000};
            w_set_unf = 1'b1;
        end else begin
            w_result = {r_s, w_exp_rnd[4:0], w_frac_sum[9:0]};
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            r_s        <= 1'b0;
            r_e        <= 6'd0;
            r_m        <= 22'd0;
            r_shift    <= 21'd0;
            r_exp      <= 8'sd0;
            r_dout     <= 16'h0000;
            r_valid    <= 1'b0;
            r_hold_cnt <= 4'd0;
        end else begin
            if (w_accept) begin
                r_s <= bus.in_s;
                r_e <= bus.in_e;
                r_m <= bus.in_m;
            end
            if (r_state == S_NORM) begin
                r_shift <= w_shifted;
                r_exp   <= w_exp_norm;
            end
            if (r_state == S_RND) begin
                r_dout     <= w_result;
                r_valid    <= 1'b1;
                r_hold_cnt <= c_HOLD_LAST;
            end
            if (r_state == S_OUT) begin
                if (r_hold_cnt == 4'd0) begin
                    r_valid <= 1'b0;
                end else begin
                    r_hold_cnt <= r_hold_cnt - 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky status flags; a clear wins over a set in the same cycle
    // ------------------------------------------------------------------
    assign w_overrun_evt = bus.in_valid && (r_state != S_IDLE);

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_overrun <= 1'b0;
        end else if (clr_flags) begin
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if ((r_state == S_RND) && w_set_ovf) begin
                r_ovf <= 1'b1;
            end
            if ((r_state == S_RND) && w_set_unf) begin
                r_unf <= 1'b1;
            end
            if (w_overrun_evt) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.dout     = r_dout;
    assign bus.valid    = r_valid;
    assign ovf          = r_ovf;
    assign unf          = r_unf;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_fmt.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_out_fmt
// Description : Directed self-checking bench for fir_out_fmt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_out_fmt;

    localparam int HOLD = 4;

    logic clk_fast;
    logic rst_n;
    logic clr_flags;
    logic ovf;
    logic unf;
    logic overrun;
    int   n_checks;
    int   n_errors;

    fir_out_fmt_if bus ();

    fir_out_fmt #(
        .EXP_BIAS29  (31),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk_fast  (clk_fast),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .clr_flags (clr_flags),
        .ovf       (ovf),
        .unf       (unf),
        .overrun   (overrun)
    );

    initial clk_fast = 1'b0;
    always #5 clk_fast = ~clk_fast;

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_wait", {15'd0, bus.in_ready}, 16'd1);
    endtask

    task automatic chk_flags(input string tag, input logic e_ovf, input logic e_unf, input logic e_ovr);
        chk({tag, "_ovf"},     {15'd0, ovf},     {15'd0, e_ovf});
        chk({tag, "_unf"},     {15'd0, unf},     {15'd0, e_unf});
        chk({tag, "_overrun"}, {15'd0, overrun}, {15'd0, e_ovr});
    endtask

    // Full transaction: capture edge, NORM edge, RND edge loads dout, then HOLD cycles of valid.
    task automatic run_vec(input string tag, input logic s, input logic [5:0] e,
                           input logic [21:0] m, input logic [15:0] exp_dout);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_s     = s;
        bus.in_e     = e;
        bus.in_m     = m;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, {15'd0, bus.in_ready}, 16'd0);
        tick();
        chk({tag, "_valid_early"}, {15'd0, bus.valid}, 16'd0);
        tick();
        chk({tag, "_dout"}, bus.dout, exp_dout);
        chk({tag, "_valid_rise"}, {15'd0, bus.valid}, 16'd1);
        for (int k = 1; k < HOLD; k++) begin
            tick();
            chk({tag, "_valid_hold"}, {15'd0, bus.valid}, 16'd1);
        end
        tick();
        chk({tag, "_valid_fall"}, {15'd0, bus.valid}, 16'd0);
        chk({tag, "_ready_back"}, {15'd0, bus.in_ready}, 16'd1);
        chk({tag, "_dout_held"}, bus.dout, exp_dout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        clr_flags    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_s     = 1'b0;
        bus.in_e     = 6'd0;
        bus.in_m     = 22'd0;
        tick();
        tick();
        chk("rst_dout", bus.dout, 16'h0000);
        chk("rst_valid", {15'd0, bus.valid}, 16'd0);
        chk("rst_ready", {15'd0, bus.in_ready}, 16'd1);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        run_vec("one",      1'b0, 6'd31, 22'h200000, 16'h3C00);
        chk_flags("one", 1'b0, 1'b0, 1'b0);
        run_vec("unnorm",   1'b1, 6'd52, 22'h000001, 16'hBC00);
        run_vec("zero",     1'b0, 6'd40, 22'h000000, 16'h0000);
        chk_flags("zero", 1'b0, 1'b0, 1'b0);
        run_vec("tie_even", 1'b0, 6'd31, 22'h200400, 16'h3C00);
        run_vec("tie_odd",  1'b0, 6'd31, 22'h200C00, 16'h3C02);
        run_vec("carry",    1'b0, 6'd31, 22'h3FFE00, 16'h4000);
        run_vec("max_norm", 1'b0, 6'd46, 22'h200000, 16'h7800);
        run_vec("min_norm", 1'b0, 6'd17, 22'h200000, 16'h0400);
        chk_flags("edges", 1'b0, 1'b0, 1'b0);

        run_vec("ovf",      1'b0, 6'd47, 22'h200000, 16'h7C00);
        chk_flags("ovf", 1'b1, 1'b0, 1'b0);
        run_vec("unf",      1'b0, 6'd16, 22'h200000, 16'h0000);
        chk_flags("unf", 1'b1, 1'b1, 1'b0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk_flags("clr", 1'b0, 1'b0, 1'b0);

        // Rounding carry pushes exponent 30 to 31
        run_vec("rnd_ovf",  1'b1, 6'd46, 22'h3FFFFF, 16'hFC00);
        chk_flags("rnd_ovf", 1'b1, 1'b0, 1'b0);
        run_vec("neg_unf",  1'b1, 6'd0,  22'h000001, 16'h8000);
        chk_flags("neg_unf", 1'b1, 1'b1, 1'b0);

        // Clear coincides with an overrun event: the clear wins
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_s     = 1'b0;
        bus.in_e     = 6'd31;
        bus.in_m     = 22'h200000;
        tick();
        clr_flags = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        clr_flags    = 1'b0;
        chk_flags("clr_prio", 1'b0, 1'b0, 1'b0);
        tick();
        chk("clr_prio_dout", bus.dout, 16'h3C00);
        chk("clr_prio_valid", {15'd0, bus.valid}, 16'd1);

        // Overrun: a second pulse one cycle after the first is dropped
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_s     = 1'b0;
        bus.in_e     = 6'd31;
        bus.in_m     = 22'h200C00;
        tick();
        bus.in_e     = 6'd47;
        bus.in_m     = 22'h200000;
        tick();
        bus.in_valid = 1'b0;
        chk("ovr_flag", {15'd0, overrun}, 16'd1);
        chk("ovr_busy", {15'd0, bus.in_ready}, 16'd0);
        tick();
        chk("ovr_dout", bus.dout, 16'h3C02);
        chk("ovr_valid", {15'd0, bus.valid}, 16'd1);
        for (int k = 1; k < HOLD; k++) begin
            tick();
            chk("ovr_busy_hold", {15'd0, bus.in_ready}, 16'd0);
        end
        tick();
        chk("ovr_valid_fall", {15'd0, bus.valid}, 16'd0);
        chk("ovr_ready_back", {15'd0, bus.in_ready}, 16'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("ovr_no_second", {15'd0, bus.valid}, 16'd0);
        end
        chk("ovr_dout_kept", bus.dout, 16'h3C02);
        chk_flags("ovr", 1'b0, 1'b0, 1'b1);

        // Reset while in RND abandons the result
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_s     = 1'b0;
        bus.in_e     = 6'd46;
        bus.in_m     = 22'h200000;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_rnd_dout", bus.dout, 16'h0000);
        chk("rst_rnd_valid", {15'd0, bus.valid}, 16'd0);
        chk_flags("rst_rnd", 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rst_no_stale_valid", {15'd0, bus.valid}, 16'd0);
            chk("rst_no_stale_dout", bus.dout, 16'h0000);
        end

        run_vec("post_rst", 1'b0, 6'd31, 22'h200000, 16'h3C00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
